hwpe_kernel_flow_tracker: RTL and testbench

Parametrised handshake tracker between the HWPE streamer and an accelerated kernel. It generalises the per-kernel adapter flag logic to N_IN sink and N_OUT source streams. Each channel has a programmable transfer threshold, so one output element may consume several inputs and one done may span several outputs. The block produces the registered ready/done/idle/error flags that the engine FSM consumes; it monitors stream handshakes only and never drives them.

---
 rtl/hwpe_kernel_flow_tracker.sv | 147 ++++++++++++++
 tb/tb_hwpe_kernel_flow_tracker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_kernel_flow_tracker.sv
// Handshake tracker between the HWPE streamer and an accelerated kernel.
// Counts per-stream transfers against latched thresholds and flags ready/done/idle/error.
module hwpe_kernel_flow_tracker #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   clear_i,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN-1:0]        in_ready_i,
  input  logic [N_OUT-1:0]       out_valid_i,
  input  logic [N_OUT-1:0]       out_ready_i,
  input  logic [N_IN*CNT_W-1:0]  in_thr_i,
  input  logic [N_OUT*CNT_W-1:0] out_thr_i,
  output logic                   ready_o,
  output logic                   done_o,
  output logic                   idle_o,
  output logic                   err_o,
  output logic [N_IN*CNT_W-1:0]  in_cnt_o,
  output logic [N_OUT*CNT_W-1:0] out_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [N_IN-1:0][CNT_W-1:0]  in_thr_q, in_thr_d;
  logic [N_IN-1:0][CNT_W-1:0]  in_cnt_q, in_cnt_d;
  logic [N_OUT-1:0][CNT_W-1:0] out_thr_q, out_thr_d;
  logic [N_OUT-1:0][CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [N_IN-1:0]             in_met_q, in_met_d;
  logic [N_OUT-1:0]            out_met_q, out_met_d;
  logic                        err_q, err_d;
  logic                        ready_q;

  logic [N_IN-1:0]  in_hs;
  logic [N_OUT-1:0] out_hs;

  assign in_hs  = in_valid_i & in_ready_i;
  assign out_hs = out_valid_i & out_ready_i;

  always_comb begin
    state_d   = state_q;
    in_thr_d  = in_thr_q;
    out_thr_d = out_thr_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    in_met_d  = in_met_q;
    out_met_d = out_met_q;
    err_d     = err_q;

    if (clear_i) begin
      state_d   = S_IDLE;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      in_met_d  = '0;
      out_met_d = '0;
      err_d     = 1'b0;
    end else if (start_i) begin
      in_thr_d  = in_thr_i;
      out_thr_d = out_thr_i;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      err_d     = 1'b0;
      for (int i = 0; i < N_IN; i++)
        in_met_d[i] = (in_thr_i[i*CNT_W +: CNT_W] == '0);
      for (int j = 0; j < N_OUT; j++)
        out_met_d[j] = (out_thr_i[j*CNT_W +: CNT_W] == '0);
      // no used output stream: the batch completes right away
      state_d = (&out_met_d) ? S_DONE : S_RUN;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|out_hs)
            err_d = 1'b1;
        end
        S_RUN: begin
          for (int i = 0; i < N_IN; i++) begin
            if (in_hs[i]) begin
              if (in_cnt_q[i] == in_thr_q[i]) begin
                in_cnt_d[i] = '0;
              end else begin
                in_cnt_d[i] = in_cnt_q[i] + CNT_W'(1);
                if (in_cnt_d[i] == in_thr_q[i])
                  in_met_d[i] = 1'b1;
              end
            end
          end
          for (int j = 0; j < N_OUT; j++) begin
            if (out_hs[j]) begin
              if (out_met_q[j]) begin
                err_d = 1'b1;
              end else begin
                out_cnt_d[j] = out_cnt_q[j] + CNT_W'(1);
                if (out_cnt_d[j] == out_thr_q[j])
                  out_met_d[j] = 1'b1;
              end
            end
          end
          if (&out_met_d)
            state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      in_thr_q  <= '0;
      out_thr_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      in_met_q  <= '0;
      out_met_q <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_thr_q  <= in_thr_d;
      out_thr_q <= out_thr_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      in_met_q  <= in_met_d;
      out_met_q <= out_met_d;
      err_q     <= err_d;
      ready_q   <= &in_met_d;
    end
  end

  assign ready_o   = ready_q;
  assign done_o    = (state_q == S_DONE);
  assign idle_o    = (state_q == S_IDLE);
  assign err_o     = err_q;
  assign in_cnt_o  = in_cnt_q;
  assign out_cnt_o = out_cnt_q;

endmodule

// File: tb/tb_hwpe_kernel_flow_tracker.sv
// Directed bench for hwpe_kernel_flow_tracker.
// Three input streams, two output streams, 8-bit counters.
module tb_hwpe_kernel_flow_tracker;

  localparam int NI = 3;
  localparam int NO = 2;
  localparam int CW = 8;

  logic clk, rst, start, clr;
  logic [NI-1:0] iv, ir;
  logic [NO-1:0] ov, orr;
  logic [CW-1:0] it0, it1, it2, ot0, ot1;
  logic ready, done, idle, err;
  logic [NI*CW-1:0] icnt;
  logic [NO*CW-1:0] ocnt;
  logic [CW-1:0] ic0, ic1, oc0, oc1;

  int n_chk = 0;
  int n_fail = 0;

  assign ic0 = icnt[0 +: CW];
  assign ic1 = icnt[CW +: CW];
  assign oc0 = ocnt[0 +: CW];
  assign oc1 = ocnt[CW +: CW];

  hwpe_kernel_flow_tracker #(
    .N_IN (NI),
    .N_OUT(NO),
    .CNT_W(CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .clear_i    (clr),
    .in_valid_i (iv),
    .in_ready_i (ir),
    .out_valid_i(ov),
    .out_ready_i(orr),
    .in_thr_i   ({it2, it1, it0}),
    .out_thr_i  ({ot1, ot0}),
    .ready_o    (ready),
    .done_o     (done),
    .idle_o     (idle),
    .err_o      (err),
    .in_cnt_o   (icnt),
    .out_cnt_o  (ocnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hs(input logic [NI-1:0] i, input logic [NO-1:0] o);
    iv = i; ir = i; ov = o; orr = o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle got=%0b want=1", idle); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0b want=0", ready); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%0b want=0", done); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b want=0", err); end
    n_chk++; if (icnt !== '0 || ocnt !== '0) begin n_fail++; $display("FAIL rst_cnt got=%h/%h want=0", icnt, ocnt); end
    rst = 1'b0;
    step();
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle2 got=%0b want=1", idle); end
  endtask

  task automatic test_basic();
    it0 = 1; it1 = 1; it2 = 1; ot0 = 4; ot1 = 0;
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (idle !== 1'b0) begin n_fail++; $display("FAIL basic_idle_fall got=%0b want=0", idle); end
    n_chk++; if (ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready0 got=%0b want=0", ready); end
    for (int k = 1; k <= 4; k++) begin
      hs(3'b111, 2'b01);
      step();
      n_chk++; if (oc0 !== CW'(k)) begin n_fail++; $display("FAIL basic_ocnt got=%0d want=%0d", oc0, k); end
      n_chk++; if (done !== (k == 4)) begin n_fail++; $display("FAIL basic_done k=%0d got=%0b", k, done); end
      n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready k=%0d got=%0b want=1", k, ready); end
    end
    hs('0, '0);
    step();
    n_chk++; if (done !== 1'b0 || idle !== 1'b1) begin n_fail++; $display("FAIL basic_end got done=%0b idle=%0b want 0/1", done, idle); end
    n_chk++; if (oc0 !== 8'd4) begin n_fail++; $display("FAIL basic_hold got=%0d want=4", oc0); end
  endtask

  task automatic test_multirate();
    it0 = 4; it1 = 2; it2 = 0; ot0 = 3; ot1 = 1;
    start = 1'b1; step(); start = 1'b0;
    hs(3'b011, 2'b01); step();
    hs(3'b011, 2'b10); step();
    n_chk++; if (done !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL mr_mid got done=%0b ready=%0b want 0/0", done, ready); end
    n_chk++; if (oc1 !== 8'd1 || ic1 !== 8'd2) begin n_fail++; $display("FAIL mr_mid_cnt got oc1=%0d ic1=%0d want 1/2", oc1, ic1); end
    hs(3'b001, 2'b01); iv[1] = 1'b1; step();
    hs(3'b001, 2'b01); step();
    hs('0, '0);
    n_chk++; if (done !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL mr_done got done=%0b ready=%0b want 1/1", done, ready); end
    n_chk++; if (ic0 !== 8'd4 || ic1 !== 8'd2) begin n_fail++; $display("FAIL mr_icnt got=%0d/%0d want=4/2", ic0, ic1); end
    n_chk++; if (oc0 !== 8'd3 || oc1 !== 8'd1) begin n_fail++; $display("FAIL mr_ocnt got=%0d/%0d want=3/1", oc0, oc1); end
    step();
    n_chk++; if (idle !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL mr_idle got idle=%0b done=%0b want 1/0", idle, done); end
  endtask

  task automatic test_unused();
    it0 = 0; it1 = 2; it2 = 0; ot0 = 0; ot1 = 0;
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (done !== 1'b1 || idle !== 1'b0) begin n_fail++; $display("FAIL un_done got done=%0b idle=%0b want 1/0", done, idle); end
    n_chk++; if (ready !== 1'b0 || icnt !== '0) begin n_fail++; $display("FAIL un_ready got ready=%0b icnt=%h want 0/0", ready, icnt); end
    step();
    n_chk++; if (idle !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL un_idle got idle=%0b done=%0b want 1/0", idle, done); end
    hs(3'b010, '0); step(); step(); hs('0, '0);
    n_chk++; if (ic1 !== 8'd0 || ready !== 1'b0) begin n_fail++; $display("FAIL un_nocount got ic1=%0d ready=%0b want 0/0", ic1, ready); end
    it1 = 0;
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (ready !== 1'b1 || done !== 1'b1) begin n_fail++; $display("FAIL un_allzero got ready=%0b done=%0b want 1/1", ready, done); end
    step();
  endtask

  task automatic test_error_b2b();
    it0 = 0; it1 = 0; it2 = 0; ot0 = 1; ot1 = 1;
    start = 1'b1; step(); start = 1'b0;
    hs('0, 2'b01); step();
    n_chk++; if (err !== 1'b0 || oc0 !== 8'd1) begin n_fail++; $display("FAIL eb_first got err=%0b oc0=%0d want 0/1", err, oc0); end
    step();
    n_chk++; if (err !== 1'b1 || oc0 !== 8'd1) begin n_fail++; $display("FAIL eb_err got err=%0b oc0=%0d want 1/1", err, oc0); end
    hs('0, 2'b10); step(); hs('0, '0);
    n_chk++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL eb_done got done=%0b err=%0b want 1/1", done, err); end
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (idle !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL eb_b2b got idle=%0b done=%0b want 0/0", idle, done); end
    n_chk++; if (err !== 1'b0 || ocnt !== '0) begin n_fail++; $display("FAIL eb_b2b_clr got err=%0b ocnt=%h want 0/0", err, ocnt); end
    clr = 1'b1; step(); clr = 1'b0;
    n_chk++; if (idle !== 1'b1) begin n_fail++; $display("FAIL eb_clear got=%0b want=1", idle); end
    hs('0, 2'b01); step(); hs('0, '0); step();
    n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL eb_idle_err got=%0b want=1", err); end
  endtask

  task automatic test_restart_clear();
    it0 = 0; it1 = 0; it2 = 0; ot0 = 5; ot1 = 0;
    start = 1'b1; step(); start = 1'b0;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rc_errclr got=%0b want=0", err); end
    hs('0, 2'b01); step(); step();
    n_chk++; if (oc0 !== 8'd2) begin n_fail++; $display("FAIL rc_cnt2 got=%0d want=2", oc0); end
    ot0 = 1;
    start = 1'b1; step(); start = 1'b0; hs('0, '0);
    n_chk++; if (oc0 !== 8'd0 || done !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL rc_restart got oc0=%0d done=%0b idle=%0b", oc0, done, idle); end
    step();
    hs('0, 2'b01); start = 1'b1; step(); start = 1'b0; hs('0, '0);
    n_chk++; if (oc0 !== 8'd0 || done !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL rc_startwins got oc0=%0d done=%0b idle=%0b", oc0, done, idle); end
    step();
    n_chk++; if (done !== 1'b0 || idle !== 1'b0) begin n_fail++; $display("FAIL rc_nodone got done=%0b idle=%0b want 0/0", done, idle); end
    clr = 1'b1; start = 1'b1; step(); clr = 1'b0; start = 1'b0;
    n_chk++; if (idle !== 1'b1 || done !== 1'b0 || ocnt !== '0) begin n_fail++; $display("FAIL rc_clear got idle=%0b done=%0b ocnt=%h", idle, done, ocnt); end
  endtask

  task automatic test_max_thr();
    it0 = 8'd255; it1 = 0; it2 = 0; ot0 = 1; ot1 = 0;
    start = 1'b1; step(); start = 1'b0;
    hs(3'b001, '0);
    repeat (254) step();
    n_chk++; if (ic0 !== 8'd254 || ready !== 1'b0) begin n_fail++; $display("FAIL max_254 got ic0=%0d ready=%0b want 254/0", ic0, ready); end
    step(); hs('0, '0);
    n_chk++; if (ic0 !== 8'd255 || ready !== 1'b1) begin n_fail++; $display("FAIL max_255 got ic0=%0d ready=%0b want 255/1", ic0, ready); end
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic test_reset_midrun();
    it0 = 1; it1 = 0; it2 = 0; ot0 = 3; ot1 = 0;
    start = 1'b1; step(); start = 1'b0;
    hs(3'b001, 2'b01); step(); hs('0, '0);
    n_chk++; if (oc0 !== 8'd1 || ready !== 1'b1) begin n_fail++; $display("FAIL rm_pre got oc0=%0d ready=%0b want 1/1", oc0, ready); end
    rst = 1'b1;
    #1;
    n_chk++; if (idle !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL rm_async got idle=%0b done=%0b ready=%0b", idle, done, ready); end
    n_chk++; if (ocnt !== '0 || icnt !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL rm_cnt got ocnt=%h icnt=%h err=%0b", ocnt, icnt, err); end
    #2 rst = 1'b0;
    step();
    n_chk++; if (idle !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL rm_after got idle=%0b done=%0b want 1/0", idle, done); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clr = 1'b0;
    iv = '0; ir = '0; ov = '0; orr = '0;
    it0 = '0; it1 = '0; it2 = '0; ot0 = '0; ot1 = '0;
    test_reset();
    test_basic();
    test_multirate();
    test_unused();
    test_error_b2b();
    test_restart_clear();
    test_max_thr();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
